// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared sizing helpers and stage payload for the pipelined CLA
package cla_pkg;

  // Widest operand a stage payload can carry; unused upper bits stay zero.
  localparam int CLA_MAX_WIDTH = 256;

  function automatic int cla_block_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit cla_params_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && (width % stages == 0) &&
           (width <= CLA_MAX_WIDTH);
  endfunction

  typedef struct packed {
    logic                     valid;
    logic [CLA_MAX_WIDTH-1:0] a_rem;
    logic [CLA_MAX_WIDTH-1:0] b_rem;
    logic [CLA_MAX_WIDTH-1:0] sum_acc;
    logic                     carry;
    logic                     cmsb;
  } cla_stage_t;

endpackage

// File: rtl/pipelined_cla_addsub_block.sv
// rtl/pipelined_cla_addsub_block.sv - combinational BLOCK-bit generate/propagate lookahead slice
module cla_block #(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;

  assign g = a & b;
  assign p = a | b;

  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign sum   = a ^ b ^ c[BLOCK-1:0];
  assign cout  = c[BLOCK];
  assign c_msb = c[BLOCK-1];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - STAGES-deep pipelined carry-lookahead adder/subtractor with handshake
module pipelined_cla_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             Zero
);

  localparam int BLOCK = cla_block_width(WIDTH, STAGES);
  localparam int MW    = CLA_MAX_WIDTH;
  localparam logic [MW-1:0] WIDTH_MASK = (MW'(1) << WIDTH) - MW'(1);

  if (!cla_params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_cla_addsub: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
  end

  logic       adv;
  cla_stage_t entry;
  cla_stage_t chain [STAGES+1];

  assign adv      = ~chain[STAGES].valid | out_ready;
  assign in_ready = adv;

  // Idle slots enter as all-zero payloads so bubbles never carry stale operands.
  always_comb begin
    entry       = '0;
    entry.valid = in_valid;
    if (in_valid) begin
      entry.a_rem = MW'(A);
      entry.b_rem = MW'(Sub ? ~B : B);
      entry.carry = Sub | Cin;
    end
  end

  assign chain[0] = entry;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * BLOCK;
    localparam logic [MW-1:0] KEEP = WIDTH_MASK & ~((MW'(1) << (LO + BLOCK)) - MW'(1));

    logic [BLOCK-1:0] blk_sum;
    logic             blk_cout;
    logic             blk_cmsb;
    cla_stage_t       nxt;
    cla_stage_t       q;

    cla_block #(.BLOCK(BLOCK)) u_blk (
      .a    (chain[k].a_rem[LO +: BLOCK]),
      .b    (chain[k].b_rem[LO +: BLOCK]),
      .cin  (chain[k].carry),
      .sum  (blk_sum),
      .cout (blk_cout),
      .c_msb(blk_cmsb)
    );

    // Consumed operand slices are cleared so only the unprocessed skew remains live.
    always_comb begin
      nxt                   = chain[k];
      nxt.a_rem             = chain[k].a_rem & KEEP;
      nxt.b_rem             = chain[k].b_rem & KEEP;
      nxt.sum_acc[LO +: BLOCK] = blk_sum;
      nxt.carry             = blk_cout;
      nxt.cmsb              = blk_cmsb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (adv) begin
        q <= nxt;
      end
    end

    assign chain[k+1] = q;
  end

  assign out_valid = chain[STAGES].valid;
  assign Sum       = chain[STAGES].sum_acc[WIDTH-1:0];
  assign Cout      = chain[STAGES].carry;
  assign Ovf       = chain[STAGES].cmsb ^ chain[STAGES].carry;
  assign Zero      = ~|chain[STAGES].sum_acc;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - directed and scoreboard checks for pipelined_cla_addsub
module tb_pipelined_cla_addsub;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipelined_cla_addsub #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a),
    .B        (b),
    .Cin      (cin),
    .Sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Sum      (sum),
    .Cout     (cout),
    .Ovf      (ovf),
    .Zero     (zero)
  );

  // Sweep instances: (WIDTH,STAGES) = (8,1), (16,2), (64,8), (12,3)
  function automatic int sw_w(input int i);
    case (i)
      0: return 8;
      1: return 16;
      2: return 64;
      default: return 12;
    endcase
  endfunction

  function automatic int sw_s(input int i);
    case (i)
      0: return 1;
      1: return 2;
      2: return 8;
      default: return 3;
    endcase
  endfunction

  logic [63:0] sw_a [4];
  logic [63:0] sw_b [4];
  logic        sw_cin = 1'b0;
  logic        sw_sub = 1'b0;
  logic        sw_in_valid = 1'b0;
  logic [3:0]  sw_in_ready;
  logic [3:0]  sw_out_valid;
  logic [3:0]  sw_cout;
  logic [3:0]  sw_ovf;
  logic [3:0]  sw_zero;
  logic [63:0] sw_sum [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_sw
    localparam int W = sw_w(gi);
    localparam int S = sw_s(gi);
    logic [W-1:0] s_sum;

    pipelined_cla_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (sw_in_valid),
      .in_ready (sw_in_ready[gi]),
      .A        (sw_a[gi][W-1:0]),
      .B        (sw_b[gi][W-1:0]),
      .Cin      (sw_cin),
      .Sub      (sw_sub),
      .out_valid(sw_out_valid[gi]),
      .out_ready(1'b1),
      .Sum      (s_sum),
      .Cout     (sw_cout[gi]),
      .Ovf      (sw_ovf[gi]),
      .Zero     (sw_zero[gi])
    );

    assign sw_sum[gi] = 64'(s_sum);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain arithmetic with semantic signed-overflow and borrow rules.
  function automatic void model(input logic [63:0] av, input logic [63:0] bv, input logic ci,
                                input logic sb, input int w, output logic [63:0] s,
                                output logic co, output logic ov);
    logic [63:0] mask;
    logic [63:0] aa;
    logic [63:0] bb;
    logic [64:0] full;
    logic        sa, sbb, ss;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    aa   = av & mask;
    bb   = bv & mask;
    if (sb) begin
      s  = (aa - bb) & mask;
      co = (aa >= bb);
    end else begin
      full = {1'b0, aa} + {1'b0, bb} + 65'(ci);
      s    = full[63:0] & mask;
      co   = full[w];
    end
    sa  = aa[w-1];
    sbb = bb[w-1];
    ss  = s[w-1];
    ov  = sb ? ((sa != sbb) && (ss != sa)) : ((sa == sbb) && (ss != sa));
  endfunction

  typedef struct {
    logic [31:0] s;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];
  int   pops = 0;
  int   run = 0;
  int   max_run = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      run = 0;
    end else begin
      if (out_valid && out_ready) begin
        run++;
        if (run > max_run) max_run = run;
        check("sb_have_expect", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          pops++;
          check("sb_sum", 64'(sum), 64'(e.s));
          check("sb_cout", 64'(cout), 64'(e.co));
          check("sb_ovf", 64'(ovf), 64'(e.ov));
          check("sb_zero", 64'(zero), 64'(e.s == 32'd0));
        end
      end else if (!out_valid) begin
        run = 0;
      end
      if (in_valid && in_ready) begin
        exp_t e;
        logic [63:0] s64;
        model(64'(a), 64'(b), cin, sub, 32, s64, e.co, e.ov);
        e.s = s64[31:0];
        exp_q.push_back(e);
      end
    end
  end

  task automatic send_op(input logic [31:0] av, input logic [31:0] bv, input logic ci, input logic sb);
    int guard = 0;
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_single(input string tag, input logic [31:0] av, input logic [31:0] bv,
                           input logic ci, input logic sb, input logic [31:0] es,
                           input logic eco, input logic eov, input logic ez);
    int cnt = 1;
    send_op(av, bv, ci, sb);
    in_valid = 1'b0;
    while (!out_valid && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check({tag, "_lat"}, 64'(cnt), 64'd4);
    check({tag, "_sum"}, 64'(sum), 64'(es));
    check({tag, "_cout"}, 64'(cout), 64'(eco));
    check({tag, "_ovf"}, 64'(ovf), 64'(eov));
    check({tag, "_zero"}, 64'(zero), 64'(ez));
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] corner(input int p, input int w);
    logic [63:0] mask;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    case (p)
      0: return 64'd0;
      1: return mask;
      default: return 64'd1 << (w - 1);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int          seen_valid;
    logic [63:0] e_s [4];
    logic        e_co [4];
    logic        e_ov [4];
    logic [3:0]  seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_zero", 64'(zero), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed vectors
    do_single("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
    do_single("sub_min", 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    do_single("sub_neg", 32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    do_single("cin_add", 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    do_single("sub_cin_ign", 32'd9, 32'd9, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);

    // Back-to-back burst at full rate
    max_run = 0;
    pops = 0;
    for (int i = 0; i < 16; i++) send_op($urandom, $urandom, 1'($urandom), 1'($urandom));
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("burst_pops", 64'(pops), 64'd16);
    check("burst_contiguous", 64'(max_run >= 16), 64'd1);
    check("burst_q_empty", 64'(exp_q.size()), 64'd0);

    // Burst with a 3-cycle backpressure window
    pops = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) send_op($urandom, $urandom, 1'($urandom), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        repeat (8) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held = sum;
        check("bp_out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("bp_in_ready", 64'(in_ready), 64'd0);
          check("bp_sum_hold", 64'(sum), 64'(held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge clk);
    #1;
    check("bp_pops", 64'(pops), 64'd16);
    check("bp_q_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset with operations in flight
    for (int i = 0; i < 4; i++) send_op(32'h1000 + 32'(i), 32'h1, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("mid_pre_valid", 64'(out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_sum", 64'(sum), 64'd0);
    check("mid_rst_zero", 64'(zero), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("mid_no_stale", 64'(seen_valid), 64'd0);
    @(posedge clk);
    #1;
    do_single("post_rst", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);

    // Parameter sweep: corner operands, then random
    for (int v = 0; v < 26; v++) begin
      @(posedge clk);
      #1;
      sw_sub = (v < 18) ? 1'(v / 9) : 1'($urandom);
      sw_cin = (v < 18) ? 1'(v % 2) : 1'($urandom);
      for (int i = 0; i < 4; i++) begin
        logic [63:0] m;
        m = corner(1, sw_w(i));
        if (v < 18) begin
          sw_a[i] = corner(v % 3, sw_w(i));
          sw_b[i] = corner((v / 3) % 3, sw_w(i));
        end else begin
          sw_a[i] = {$urandom, $urandom} & m;
          sw_b[i] = {$urandom, $urandom} & m;
        end
        model(sw_a[i], sw_b[i], sw_cin, sw_sub, sw_w(i), e_s[i], e_co[i], e_ov[i]);
      end
      sw_in_valid = 1'b1;
      @(posedge clk);
      #1;
      sw_in_valid = 1'b0;
      seen = '0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
        for (int i = 0; i < 4; i++) begin
          if (sw_out_valid[i] && !seen[i]) begin
            seen[i] = 1'b1;
            check($sformatf("sw%0d_lat", i), 64'(cyc), 64'(sw_s(i)));
            check($sformatf("sw%0d_sum_v%0d", i, v), sw_sum[i], e_s[i]);
            check($sformatf("sw%0d_cout_v%0d", i, v), 64'(sw_cout[i]), 64'(e_co[i]));
            check($sformatf("sw%0d_ovf_v%0d", i, v), 64'(sw_ovf[i]), 64'(e_ov[i]));
            check($sformatf("sw%0d_zero_v%0d", i, v), 64'(sw_zero[i]), 64'(e_s[i] == 64'd0));
          end
        end
        @(posedge clk);
        #1;
      end
      for (int i = 0; i < 4; i++) begin
        if (!seen[i]) check($sformatf("sw%0d_timeout_v%0d", i, v), 64'(seen[i]), 64'd1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
